vexriscv_ram_arbiter: RTL and testbench

- Shares one byte-write RAM port (the dbus port of the dual-port VexRiscv RAM) between two requesters: the CPU data bus (cpu_*) and the UART/debug program loader (ldr_*).
- Arbitrates per cycle with round-robin priority on contention.
- Drives the RAM port and routes each 1-cycle-latency read response back to the requester that issued it.
- Sits between the CPU dBus adapter and the RAM; the ibus port stays direct.

---
 rtl/vexriscv_ram_arbiter.sv | 116 +++++++++++
 tb/tb_vexriscv_ram_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vexriscv_ram_arbiter.sv
// Round-robin arbiter that shares the VexRiscv dbus RAM port between the CPU and the program loader.
// Optional feature macro: VEXRISCV_RAM_ARB_LOCK_EN (adds ldr_lock / cpu_locked for exclusive loader access).
module vexriscv_ram_arbiter #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 1024,
    localparam int AW = $clog2(RAM_DEPTH-1),
    localparam int DW = NB_COL*COL_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_cmd_valid,
    output logic              cpu_cmd_ready,
    input  logic              cpu_cmd_wr,
    input  logic [AW-1:0]     cpu_cmd_addr,
    input  logic [DW-1:0]     cpu_cmd_data,
    input  logic [NB_COL-1:0] cpu_cmd_mask,
    output logic              cpu_rsp_valid,
    output logic [DW-1:0]     cpu_rsp_data,
    input  logic              ldr_cmd_valid,
    output logic              ldr_cmd_ready,
    input  logic              ldr_cmd_wr,
    input  logic [AW-1:0]     ldr_cmd_addr,
    input  logic [DW-1:0]     ldr_cmd_data,
    input  logic [NB_COL-1:0] ldr_cmd_mask,
    output logic              ldr_rsp_valid,
    output logic [DW-1:0]     ldr_rsp_data,
`ifdef VEXRISCV_RAM_ARB_LOCK_EN
    input  logic              ldr_lock,
    output logic              cpu_locked,
`endif
    output logic              ram_en,
    output logic [NB_COL-1:0] ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    logic              w_lock;
    logic              w_gnt_cpu;
    logic              w_gnt_ldr;
    logic              w_gnt;
    logic              w_wr;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_din;
    logic [NB_COL-1:0] w_mask;

    // 0 = CPU, 1 = loader; resets to loader so the CPU wins the first contention.
    logic              r_last_grant;
    logic              r_rd_pend;
    logic              r_rd_owner;

`ifdef VEXRISCV_RAM_ARB_LOCK_EN
    logic              r_cpu_locked;

    assign w_lock     = ldr_lock;
    assign cpu_locked = r_cpu_locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_locked <= 1'b0;
        end else begin
            r_cpu_locked <= ldr_lock;
        end
    end
`else
    assign w_lock = 1'b0;
`endif

    // Under contention the requester that did not win last time is served.
    assign w_gnt_cpu = !rst && cpu_cmd_valid && !w_lock && (!ldr_cmd_valid || r_last_grant);
    assign w_gnt_ldr = !rst && ldr_cmd_valid && (w_lock || !cpu_cmd_valid || !r_last_grant);
    assign w_gnt     = w_gnt_cpu || w_gnt_ldr;

    assign cpu_cmd_ready = w_gnt_cpu;
    assign ldr_cmd_ready = w_gnt_ldr;

    always_comb begin
        w_wr   = cpu_cmd_wr;
        w_addr = cpu_cmd_addr;
        w_din  = cpu_cmd_data;
        w_mask = cpu_cmd_mask;
        if (w_gnt_ldr) begin
            w_wr   = ldr_cmd_wr;
            w_addr = ldr_cmd_addr;
            w_din  = ldr_cmd_data;
            w_mask = ldr_cmd_mask;
        end
    end

    assign ram_en   = w_gnt;
    assign ram_we   = (w_gnt && w_wr) ? w_mask : '0;
    assign ram_addr = w_addr;
    assign ram_din  = w_din;

    // Locked grants leave the round-robin pointer untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            if (w_gnt && !w_lock) begin
                r_last_grant <= w_gnt_ldr;
            end
            r_rd_pend  <= w_gnt && !w_wr;
            r_rd_owner <= w_gnt_ldr;
        end
    end

    assign cpu_rsp_valid = !rst && r_rd_pend && !r_rd_owner;
    assign ldr_rsp_valid = !rst && r_rd_pend && r_rd_owner;
    assign cpu_rsp_data  = ram_dout;
    assign ldr_rsp_data  = ram_dout;

endmodule

// File: tb/tb_vexriscv_ram_arbiter.sv
// Self-checking bench for vexriscv_ram_arbiter: behavioural byte-write RAM, reference arbiter model and response scoreboard.
module tb_vexriscv_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cmd_valid, cpu_cmd_ready, cpu_cmd_wr;
    logic [9:0]  cpu_cmd_addr;
    logic [31:0] cpu_cmd_data;
    logic [3:0]  cpu_cmd_mask;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_data;
    logic        ldr_cmd_valid, ldr_cmd_ready, ldr_cmd_wr;
    logic [9:0]  ldr_cmd_addr;
    logic [31:0] ldr_cmd_data;
    logic [3:0]  ldr_cmd_mask;
    logic        ldr_rsp_valid;
    logic [31:0] ldr_rsp_data;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
`ifdef VEXRISCV_RAM_ARB_LOCK_EN
    logic        ldr_lock;
    logic        cpu_locked;
`endif

    always #5 clk = ~clk;

    vexriscv_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
        .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_data(cpu_cmd_data), .cpu_cmd_mask(cpu_cmd_mask),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .ldr_cmd_valid(ldr_cmd_valid), .ldr_cmd_ready(ldr_cmd_ready), .ldr_cmd_wr(ldr_cmd_wr),
        .ldr_cmd_addr(ldr_cmd_addr), .ldr_cmd_data(ldr_cmd_data), .ldr_cmd_mask(ldr_cmd_mask),
        .ldr_rsp_valid(ldr_rsp_valid), .ldr_rsp_data(ldr_rsp_data),
`ifdef VEXRISCV_RAM_ARB_LOCK_EN
        .ldr_lock(ldr_lock), .cpu_locked(cpu_locked),
`endif
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural RAM: byte writes, 1-cycle read latency, cleared while reset is held.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (ram_en) begin
            if (ram_we == 4'b0000) ram_dout <= mem[ram_addr];
            else for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
    end

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sbq[$];
    logic [31:0] exp_mem [0:1023];
    logic        m_lg;
    logic        m_locked;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle with the inputs the caller has already driven.
    task automatic cycle();
        logic        lock_v, ecg, elg, egnt, ewr, has;
        logic [9:0]  ead;
        logic [31:0] ed;
        logic [3:0]  emk;
        rsp_t        e;
        #1;
`ifdef VEXRISCV_RAM_ARB_LOCK_EN
        lock_v = ldr_lock;
        check_eq("cpu_locked", {31'd0, cpu_locked}, {31'd0, m_locked});
`else
        lock_v = 1'b0;
`endif
        ecg = 1'b0;
        elg = 1'b0;
        if (!rst) begin
            if (lock_v) elg = ldr_cmd_valid;
            else if (cpu_cmd_valid && ldr_cmd_valid) begin
                if (m_lg) ecg = 1'b1;
                else      elg = 1'b1;
            end else begin
                ecg = cpu_cmd_valid;
                elg = ldr_cmd_valid;
            end
        end
        egnt = ecg || elg;
        ewr  = elg ? ldr_cmd_wr   : cpu_cmd_wr;
        ead  = elg ? ldr_cmd_addr : cpu_cmd_addr;
        ed   = elg ? ldr_cmd_data : cpu_cmd_data;
        emk  = elg ? ldr_cmd_mask : cpu_cmd_mask;

        check_eq("cpu_ready", {31'd0, cpu_cmd_ready}, {31'd0, ecg});
        check_eq("ldr_ready", {31'd0, ldr_cmd_ready}, {31'd0, elg});
        check_eq("ram_en", {31'd0, ram_en}, {31'd0, egnt});
        check_eq("ram_we", {28'd0, ram_we}, {28'd0, (egnt && ewr) ? emk : 4'b0000});
        if (egnt) begin
            check_eq("ram_addr", {22'd0, ram_addr}, {22'd0, ead});
            if (ewr) check_eq("ram_din", ram_din, ed);
        end

        has = 1'b0;
        e   = '0;
        if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            has = !rst;
        end
        check_eq("cpu_rsp_valid", {31'd0, cpu_rsp_valid}, {31'd0, has && !e.owner});
        check_eq("ldr_rsp_valid", {31'd0, ldr_rsp_valid}, {31'd0, has && e.owner});
        if (has && !e.owner) check_eq("cpu_rsp_data", cpu_rsp_data, e.data);
        if (has && e.owner)  check_eq("ldr_rsp_data", ldr_rsp_data, e.data);

        if (egnt && !ewr) sbq.push_back('{owner: elg, data: exp_mem[ead]});
        if (egnt && ewr)
            for (int b = 0; b < 4; b++)
                if (emk[b]) exp_mem[ead][8*b +: 8] = ed[8*b +: 8];

        @(posedge clk);
        if (rst) begin
            m_lg     = 1'b1;
            m_locked = 1'b0;
            for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        end else begin
            if (egnt && !lock_v) m_lg = elg;
            m_locked = lock_v;
        end
        #1;
    endtask

    task automatic drive_cpu(input logic v, input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        cpu_cmd_valid = v; cpu_cmd_wr = wr; cpu_cmd_addr = a; cpu_cmd_data = d; cpu_cmd_mask = m;
    endtask

    task automatic drive_ldr(input logic v, input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        ldr_cmd_valid = v; ldr_cmd_wr = wr; ldr_cmd_addr = a; ldr_cmd_data = d; ldr_cmd_mask = m;
    endtask

    task automatic idle();
        drive_cpu(1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
        drive_ldr(1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m_lg = 1'b1;
        m_locked = 1'b0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
`ifdef VEXRISCV_RAM_ARB_LOCK_EN
        ldr_lock = 1'b0;
`endif
        idle();
        cpu_cmd_valid = 1'b1;
        #1 check_eq("reset_ready", {31'd0, cpu_cmd_ready}, 32'd0);
        cycle();
        idle();
        cycle();
        rst = 1'b0;

        // Continuous contention from reset: CPU, LDR, CPU, ...
        drive_cpu(1'b1, 1'b0, 10'd1, 32'd0, 4'd0);
        drive_ldr(1'b1, 1'b0, 10'd2, 32'd0, 4'd0);
        #1 check_eq("contention_cpu_first", {31'd0, cpu_cmd_ready}, 32'd1);
        repeat (6) cycle();
        idle();
        cycle();

        drive_ldr(1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 4'b1111);
        cycle();
        idle();
        drive_cpu(1'b1, 1'b0, 10'd5, 32'd0, 4'd0);
        cycle();
        idle();
        #1 check_eq("cpu_read_deadbeef", cpu_rsp_data, 32'hDEADBEEF);
        check_eq("cpu_read_ldr_quiet", {31'd0, ldr_rsp_valid}, 32'd0);
        cycle();

        drive_ldr(1'b1, 1'b1, 10'd7, 32'h11223344, 4'b0101);
        #1 check_eq("byte_write_we", {28'd0, ram_we}, 32'h5);
        cycle();
        drive_ldr(1'b1, 1'b0, 10'd7, 32'd0, 4'd0);
        cycle();
        idle();
        #1 check_eq("byte_write_merge", ldr_rsp_data, 32'h00220044);
        cycle();

        drive_cpu(1'b1, 1'b1, 10'd3, 32'hCAFEF00D, 4'b1111);
        cycle();
        drive_cpu(1'b1, 1'b0, 10'd3, 32'd0, 4'd0);
        cycle();
        idle();
        #1 check_eq("write_then_read", cpu_rsp_data, 32'hCAFEF00D);
        cycle();

        drive_cpu(1'b1, 1'b1, 10'd3, 32'h0, 4'b0000);
        cycle();
        drive_cpu(1'b1, 1'b0, 10'd3, 32'd0, 4'd0);
        cycle();
        idle();
        cycle();

`ifdef VEXRISCV_RAM_ARB_LOCK_EN
        drive_ldr(1'b1, 1'b0, 10'd4, 32'd0, 4'd0);
        cycle();
        ldr_lock = 1'b1;
        drive_cpu(1'b1, 1'b0, 10'd3, 32'd0, 4'd0);
        drive_ldr(1'b1, 1'b0, 10'd7, 32'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("lock_cpu_blocked", {31'd0, cpu_cmd_ready}, 32'd0);
            cycle();
        end
        ldr_lock = 1'b0;
        #1 check_eq("unlock_cpu_next", {31'd0, cpu_cmd_ready}, 32'd1);
        cycle();
        idle();
        cycle();
`endif

        for (int k = 0; k < 300; k++) begin
            drive_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
                      $urandom, 4'($urandom_range(0, 15)));
            drive_ldr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
                      $urandom, 4'($urandom_range(0, 15)));
`ifdef VEXRISCV_RAM_ARB_LOCK_EN
            ldr_lock = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end
`ifdef VEXRISCV_RAM_ARB_LOCK_EN
        ldr_lock = 1'b0;
`endif
        idle();
        cycle();

        // Reset in the middle of traffic: CPU read right before and during reset.
        drive_cpu(1'b1, 1'b0, 10'd1, 32'd0, 4'd0);
        cycle();
        rst = 1'b1;
        #1 check_eq("rst_rise_ready", {31'd0, cpu_cmd_ready}, 32'd0);
        cycle();
        rst = 1'b0;
        drive_ldr(1'b1, 1'b0, 10'd2, 32'd0, 4'd0);
        #1 check_eq("rst_drop_no_rsp", {31'd0, cpu_rsp_valid}, 32'd0);
        check_eq("rst_drop_cpu_first", {31'd0, cpu_cmd_ready}, 32'd1);
        cycle();
        cycle();
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
